scoreboard_display_seq: RTL and testbench

Parametrised display sequencer for the scoreboard: cycles round-robin through up to nine players on one two-digit display. Each player's turn is a blinking "P<n>" announcement followed by that player's score. Disabled players are skipped, and the rotation can be held or advanced manually. It sits between the score counters and the BCD-to-7-segment decoder, and drives the same digit code space (0–9 digits, 10 = off, 11 = 'P').

---
 rtl/scoreboard_display_seq_if.sv | 21 ++
 rtl/scoreboard_display_seq.sv | 105 ++++++++++
 tb/tb_scoreboard_display_seq.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/scoreboard_display_seq_if.sv
// scoreboard_display_seq_if: score/mask/control inputs and digit outputs of the display sequencer.
interface scoreboard_display_seq_if #(
  parameter int N_PLAYERS = 2
);
  logic [8*N_PLAYERS-1:0] scores_i;
  logic [N_PLAYERS-1:0]   players_en_i;
  logic                   hold_i;
  logic                   next_i;
  logic [3:0]             tens_o;
  logic [3:0]             ones_o;
  logic [3:0]             player_o;
  logic                   blink_phase_o;
  modport master (
    output scores_i, players_en_i, hold_i, next_i,
    input  tens_o, ones_o, player_o, blink_phase_o
  );
  modport slave (
    input  scores_i, players_en_i, hold_i, next_i,
    output tens_o, ones_o, player_o, blink_phase_o
  );
endinterface

// File: rtl/scoreboard_display_seq.sv
// scoreboard_display_seq: round-robin "P<n>" blink + score display sequencer; define SCOREBOARD_SNAPSHOT_EN to latch the score on DISPLAY entry.
module scoreboard_display_seq #(
  parameter int N_PLAYERS     = 2,
  parameter int BLINK_MS      = 500,
  parameter int DISPLAY_MS    = 2000,
  parameter int BLINK_TOGGLES = 4
) (
  input logic clk_1khz,
  input logic rst_i,
  scoreboard_display_seq_if.slave bus
);
  localparam int PW = $clog2(N_PLAYERS);
  localparam int MS = BLINK_MS > DISPLAY_MS ? BLINK_MS : DISPLAY_MS;
  localparam int TW = $clog2(MS + 1);
  localparam int IW = $clog2(BLINK_TOGGLES);
  typedef enum logic [1:0] {IDLE, BLINK, DISPLAY} state_t;
  state_t st, st_n;
  logic [PW-1:0] p, p_n, p_lo, p_nx;
  logic [TW-1:0] t, t_n;
  logic [IW-1:0] i, i_n;
  logic [N_PLAYERS-1:0] dm;
  logic [7:0] sa [N_PLAYERS];
  logic [7:0] shown;
  logic [3:0] tens_n, ones_n, player_n;
  logic blink_n;
  for (genvar g = 0; g < N_PLAYERS; g++) begin : g_sa
    assign sa[g] = bus.scores_i[8*g +: 8];
  end
  // dm[j] is the enable of player (p+j+1) mod N, so the first set bit is the next player
  always_comb begin
    dm = N_PLAYERS'({bus.players_en_i, bus.players_en_i} >> p >> 1);
    p_lo = '0;
    for (int k = N_PLAYERS - 1; k >= 0; k--) if (bus.players_en_i[k]) p_lo = PW'(k);
    p_nx = p;
    for (int j = N_PLAYERS - 1; j >= 0; j--)
      if (dm[j]) p_nx = PW'(int'(p) + j + 1 >= N_PLAYERS ? int'(p) + j + 1 - N_PLAYERS : int'(p) + j + 1);
  end
  always_comb begin
    st_n = st;
    p_n = p;
    t_n = t;
    i_n = i;
    if (bus.players_en_i == '0) begin
      st_n = IDLE;
      p_n = '0;
      t_n = '0;
      i_n = '0;
    end else if (st == IDLE || bus.next_i) begin
      st_n = BLINK;
      p_n = st == IDLE ? p_lo : p_nx;
      t_n = '0;
      i_n = '0;
    end else if (!bus.hold_i) begin
      if (st == BLINK) begin
        t_n = t == TW'(BLINK_MS - 1) ? '0 : t + 1'b1;
        if (t == TW'(BLINK_MS - 1)) begin
          i_n = i == IW'(BLINK_TOGGLES - 1) ? '0 : i + 1'b1;
          st_n = i == IW'(BLINK_TOGGLES - 1) ? DISPLAY : BLINK;
        end
      end else begin
        t_n = t == TW'(DISPLAY_MS - 1) ? '0 : t + 1'b1;
        st_n = t == TW'(DISPLAY_MS - 1) ? BLINK : DISPLAY;
        p_n = t == TW'(DISPLAY_MS - 1) ? p_nx : p;
      end
    end
  end
`ifdef SCOREBOARD_SNAPSHOT_EN
  logic [7:0] snap;
  always_ff @(posedge clk_1khz)
    if (rst_i) snap <= '0;
    else if (st != DISPLAY && st_n == DISPLAY) snap <= sa[p_n];
  assign shown = st == DISPLAY ? snap : sa[p_n];
`else
  assign shown = sa[p_n];
`endif
  always_comb begin
    tens_n = st_n == DISPLAY ? (shown[7:4] > 4'd9 ? 4'd10 : shown[7:4]) :
             st_n == BLINK && !i_n[0] ? 4'd11 : 4'd10;
    ones_n = st_n == DISPLAY ? (shown[3:0] > 4'd9 ? 4'd10 : shown[3:0]) :
             st_n == BLINK && !i_n[0] ? 4'(p_n) + 4'd1 : 4'd10;
    player_n = st_n == IDLE ? 4'd0 : 4'(p_n) + 4'd1;
    blink_n = st_n == BLINK;
  end
  always_ff @(posedge clk_1khz) begin
    if (rst_i) begin
      st <= IDLE;
      p <= '0;
      t <= '0;
      i <= '0;
      bus.tens_o <= 4'd10;
      bus.ones_o <= 4'd10;
      bus.player_o <= 4'd0;
      bus.blink_phase_o <= 1'b0;
    end else begin
      st <= st_n;
      p <= p_n;
      t <= t_n;
      i <= i_n;
      bus.tens_o <= tens_n;
      bus.ones_o <= ones_n;
      bus.player_o <= player_n;
      bus.blink_phase_o <= blink_n;
    end
  end
endmodule

// File: tb/tb_scoreboard_display_seq.sv
// tb_scoreboard_display_seq: scoreboard bench with a turn-position reference model and randomized stimulus.
module tb_scoreboard_display_seq;
  localparam int N = 3, B = 4, D = 8, T = 4, BL = T * B, TURN = BL + D;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  scoreboard_display_seq_if #(.N_PLAYERS(N)) bus();
  scoreboard_display_seq #(.N_PLAYERS(N), .BLINK_MS(B), .DISPLAY_MS(D), .BLINK_TOGGLES(T)) dut (
    .clk_1khz(clk), .rst_i(rst), .bus(bus)
  );
  logic [12:0] q[$];
  int n_checks = 0, n_pass = 0;
  bit midle = 1;
  int mp = 0, mc = 0;
  logic [7:0] msnap = 0;
  function automatic int nextp(int p, logic [N-1:0] en);
    logic [N-1:0] r;
    for (int k = 1; k <= N; k++) begin
      r = en >> ((p + k) % N);
      if (r[0]) return (p + k) % N;
    end
    return p;
  endfunction
  function automatic int lowest(logic [N-1:0] en);
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) begin
      r = en >> k;
      if (r[0]) return k;
    end
    return 0;
  endfunction
  // model position mc runs 0..TURN-1 through one turn: 0..BL-1 announcement, BL.. score
  task automatic step();
    logic [7:0] sc;
    logic [3:0] te, on, pl;
    logic bl;
    bit prev;
    prev = !midle && mc >= BL;
    if (rst || bus.players_en_i == 0) begin
      midle = 1; mp = 0; mc = 0;
    end else if (midle) begin
      midle = 0; mp = lowest(bus.players_en_i); mc = 0;
    end else if (bus.next_i) begin
      mp = nextp(mp, bus.players_en_i); mc = 0;
    end else if (!bus.hold_i) begin
      mc++;
      if (mc == TURN) begin
        mc = 0; mp = nextp(mp, bus.players_en_i);
      end
    end
    sc = 8'(bus.scores_i >> (8 * mp));
    if (!midle && mc >= BL && !prev) msnap = sc;
`ifdef SCOREBOARD_SNAPSHOT_EN
    if (!midle && mc >= BL) sc = msnap;
`endif
    if (midle) begin
      te = 10; on = 10; pl = 0; bl = 0;
    end else if (mc < BL) begin
      pl = 4'(mp + 1); bl = 1;
      te = (mc / B) % 2 == 0 ? 4'd11 : 4'd10;
      on = (mc / B) % 2 == 0 ? 4'(mp + 1) : 4'd10;
    end else begin
      pl = 4'(mp + 1); bl = 0;
      te = sc[7:4] > 9 ? 4'd10 : sc[7:4];
      on = sc[3:0] > 9 ? 4'd10 : sc[3:0];
    end
    q.push_back({te, on, pl, bl});
  endtask
  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      step();
    end
  endtask
  task automatic wait_pos(int pp, int cc);
    int n = 0;
    while (!(!midle && mp == pp && mc == cc) && n < 500) begin
      cyc(1);
      n++;
    end
    if (n >= 500) begin
      n_checks++;
      $display("FAIL wait_pos: player %0d pos %0d not reached, model at %0d/%0d", pp, cc, mp, mc);
    end
  endtask
  always @(negedge clk) begin
    logic [12:0] e, a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {bus.tens_o, bus.ones_o, bus.player_o, bus.blink_phase_o};
      n_checks++;
      if (a === e) n_pass++;
      else $display("FAIL out @%0t: tens/ones/player/blink got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                    $time, a[12:9], a[8:5], a[4:1], a[0], e[12:9], e[8:5], e[4:1], e[0]);
    end
  end
  initial begin
    bus.scores_i = {8'h56, 8'h34, 8'h12};
    bus.players_en_i = 3'b111;
    bus.hold_i = 0;
    bus.next_i = 0;
    cyc(3);
    rst = 0;
    cyc(3 * TURN + 5);
    bus.players_en_i = 3'b101;
    cyc(3 * TURN);
    wait_pos(2, BL + 2);
    bus.players_en_i = 3'b000;
    cyc(3);
    bus.players_en_i = 3'b111;
    wait_pos(0, BL + 4);
    bus.next_i = 1;
    cyc(1);
    bus.next_i = 0;
    cyc(5);
    bus.hold_i = 1;
    bus.next_i = 1;
    cyc(1);
    bus.next_i = 0;
    cyc(3);
    bus.hold_i = 0;
    wait_pos(1, 5);
    bus.hold_i = 1;
    cyc(10);
    bus.hold_i = 0;
    cyc(30);
    bus.scores_i[23:16] = 8'hA3;
    wait_pos(2, BL + 1);
    cyc(8);
    wait_pos(0, BL + 2);
    bus.scores_i[7:0] = 8'h13;
    cyc(4);
    bus.hold_i = 1;
    cyc(3);
    bus.hold_i = 0;
    cyc(4);
    rst = 1;
    cyc(2);
    rst = 0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 39) == 0) bus.players_en_i = 3'($urandom_range(0, 9) < 2 ? 0 : $urandom_range(1, 7));
      if ($urandom_range(0, 9) == 0) bus.scores_i[8 * $urandom_range(0, N - 1) +: 8] = 8'($urandom);
      if ($urandom_range(0, 24) == 0) bus.hold_i = !bus.hold_i;
      bus.next_i = $urandom_range(0, 29) == 0;
      rst = $urandom_range(0, 299) == 0;
      cyc(1);
    end
    bus.next_i = 0;
    rst = 0;
    cyc(2);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
